// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : Operand/result handshake bundle for the serial subtractor.
//             The master side presents operands and consumes results; the
//             slave side is the subtractor itself.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  // Operand channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  // Producer of operands / consumer of results
  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    input  out_valid,
    output out_ready,
    input  diff,
    input  borrow_out,
    input  overflow,
    input  zero
  );

  // The subtractor
  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    output out_valid,
    input  out_ready,
    output diff,
    output borrow_out,
    output overflow,
    output zero
  );

endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned/two's-complement subtractor. Operands are
//             latched on acceptance, one difference bit is produced per cycle
//             LSB first, and the result is held until the consumer takes it.
//             Flags: borrow (unsigned a < b), signed overflow, zero.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8            // operand/result width, 2..32
) (
  input  logic               clk,
  input  logic               rst_n,  // synchronous, active low
  serial_subtractor_if.slave bus
);

  // Counter holds 0..WIDTH, so it never wraps inside RUN
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;          // minuend shift register
  logic [WIDTH-1:0] b_q;          // subtrahend shift register
  logic [WIDTH-1:0] res_q;        // result, filled from the MSB side
  logic             bor_q;        // running borrow
  logic [CNT_W-1:0] cnt_q;        // bits processed so far
  logic             a_msb_q;      // original operand sign bits, kept for
  logic             b_msb_q;      // the overflow decision at the end
  logic             in_ready_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic             zero_q;

  logic             diff_bit_d;
  logic             bor_d;
  logic [WIDTH-1:0] res_d;
  logic             overflow_d;
  logic             zero_d;

  // One full-subtractor stage on the current LSBs, plus the flags the
  // final result would produce if this were the last bit.
  always_comb begin
    diff_bit_d = a_q[0] ^ b_q[0] ^ bor_q;
    bor_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    res_d      = {diff_bit_d, res_q[WIDTH-1:1]};
    overflow_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
    zero_d     = (res_d == '0);
  end

  // Control FSM and datapath registers; all outputs come from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      bor_q       <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            a_msb_q    <= bus.a[WIDTH-1];
            b_msb_q    <= bus.b[WIDTH-1];
            res_q      <= '0;
            bor_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          res_q <= res_d;
          bor_q <= bor_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_BIT) begin
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // Result stays frozen until the consumer takes it; no accept
          // happens on the same edge, so the next operand waits for IDLE.
          if (bus.out_ready) begin
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Result fields read zero whenever no result is being offered.
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = out_valid_q ? res_q : '0;
  assign bus.borrow_out = out_valid_q & bor_q;
  assign bus.overflow   = overflow_q;
  assign bus.zero       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8):
//             directed vectors, handshake corner cases, random traffic and
//             a full sweep of every operand pair on a bank of instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int NL = 64;   // parallel instances for the full operand sweep

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wire [10:0] w_out = {bus.diff, bus.borrow_out, bus.overflow, bus.zero};

  // ---------------- sweep bank ----------------
  logic             lane_in_valid;
  logic             lane_out_ready;
  logic [W-1:0]     la    [NL];
  logic [W-1:0]     lb    [NL];
  logic [W-1:0]     ldiff [NL];
  logic [NL-1:0]    l_in_ready, l_out_valid, lbor, lovf, lzero;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    serial_subtractor_if #(.WIDTH(W)) lif ();
    assign lif.in_valid  = lane_in_valid;
    assign lif.out_ready = lane_out_ready;
    assign lif.a         = la[g];
    assign lif.b         = lb[g];
    assign l_in_ready[g]  = lif.in_ready;
    assign l_out_valid[g] = lif.out_valid;
    assign ldiff[g]       = lif.diff;
    assign lbor[g]        = lif.borrow_out;
    assign lovf[g]        = lif.overflow;
    assign lzero[g]       = lif.zero;
    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lif)
    );
  end

  // ---------------- reference model ----------------
  // Arithmetic view: {diff, borrow, overflow, zero}
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, sd;
    logic [7:0] df;
    logic bo, ov, zr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    df = 8'((ua - ub + 256) % 256);
    bo = (ua < ub);
    sd = sa - sb;
    ov = (sd > 127) || (sd < -128);
    zr = (df == 8'd0);
    return {df, bo, ov, zr};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance: accept, count latency, optionally
  // hold the result under backpressure, then hand it off.
  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [10:0] exp, input int hold);
    int t;
    int lat;
    logic [10:0] first;
    t = 0;
    while (!bus.in_ready && t < 30) begin tick(); t++; end
    check({nm, " ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom);  // must not disturb the op
    check({nm, " run_state"}, {20'd0, bus.in_ready, w_out}, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      bus.out_ready = 1'($urandom);               // ignored outside DONE
      tick();
      lat++;
    end
    bus.out_ready = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(W));
    first = w_out;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({nm, " hold"}, {20'd0, bus.out_valid, w_out}, {20'd0, 1'b1, first});
    end
    check({nm, " result"}, 32'(w_out), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, " release"}, {20'd0, bus.in_ready, bus.out_valid, w_out},
          {20'd0, 1'b1, 1'b0, 11'd0});
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] exp;   // {diff, borrow, overflow, zero}
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] e;
    logic [15:0] idx;
    int lat;
    logic timed_out;

    vecs[0] = '{8'hC8, 8'h37, {8'h91, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{8'h00, 8'h01, {8'hFF, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{8'h80, 8'h01, {8'h7F, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{8'h7F, 8'hFF, {8'h80, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{8'h5A, 8'h5A, {8'h00, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{8'h01, 8'h80, {8'h81, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{8'hFF, 8'h00, {8'hFF, 1'b0, 1'b0, 1'b0}};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    lane_in_valid = 1'b0; lane_out_ready = 1'b0;
    for (int l = 0; l < NL; l++) begin la[l] = '0; lb[l] = '0; end

    // Reset, with in_valid asserted on the reset edges
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
    tick(); tick();
    check("reset_state", {20'd0, bus.in_ready, bus.out_valid, w_out},
          {20'd0, 1'b1, 1'b0, 11'd0});
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("reset_no_accept", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 0 : 1);
    end

    // Backpressure: result held 5 cycles while new operands wait
    bus.a = 8'hC8; bus.b = 8'h37; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin tick(); lat++; end
    check("bp latency", 32'(lat), 32'd8);
    bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold", {20'd0, bus.in_ready, bus.out_valid, w_out},
            {20'd0, 1'b0, 1'b1, 8'h91, 3'b000});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp to_idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
    tick();
    bus.in_valid = 1'b0;
    check("bp accept", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin tick(); lat++; end
    check("bp second_latency", 32'(lat), 32'd8);
    check("bp second_result", 32'(w_out), 32'(model(8'h11, 8'h22)));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset in the middle of RUN after three bits
    bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset", {20'd0, bus.in_ready, bus.out_valid, w_out},
          {20'd0, 1'b1, 1'b0, 11'd0});
    do_op("after_reset", 8'h10, 8'h01, {8'h0F, 3'b000}, 0);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom); rb = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      do_op("rand", ra, rb, model(ra, rb), $urandom_range(0, 3));
    end

    // Full operand sweep across the bank
    timed_out = 1'b0;
    for (int k = 0; k < 65536 / NL && !timed_out; k++) begin
      for (int l = 0; l < NL; l++) begin
        idx = 16'(k * NL + l);
        la[l] = idx[15:8];
        lb[l] = idx[7:0];
      end
      lane_in_valid = 1'b1;
      tick();
      lane_in_valid = 1'b0;
      lat = 0;
      while (!(&l_out_valid) && lat < 30) begin tick(); lat++; end
      if (lat >= 30) begin
        timed_out = 1'b1;
        check("sweep timeout", 32'(l_out_valid), 32'hFFFF_FFFF);
      end else begin
        for (int l = 0; l < NL; l++) begin
          e = model(la[l], lb[l]);
          check($sformatf("sweep a=%h b=%h", la[l], lb[l]),
                32'({ldiff[l], lbor[l], lovf[l], lzero[l]}), 32'(e));
        end
      end
      lane_out_ready = 1'b1;
      tick();
      lane_out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port: in_valid  input  1  operands a, b presented.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port: a  input  WIDTH  minuend.
REQ-007 The block SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 The block SHALL have port: out_valid  output  1  result available.
REQ-009 The block SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 The block SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 The block SHALL have port: borrow_out  output  1  unsigned a < b.
REQ-012 The block SHALL have port: overflow  output  1  signed (two's complement) overflow of a - b.
REQ-013 The block SHALL have port: zero  output  1  diff == 0.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 IDLE: on in_valid && in_ready at an edge, SHALL latch a and b into shift registers, clear borrow flop to 0, clear bit counter, clear the result register, and go to RUN.
REQ-016 RUN: each cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ bor; bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor).
REQ-017 RUN: each cycle SHALL shift d into the result register from the MSB side and shift both operand registers right by one.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, state SHALL go to DONE.
REQ-019 Latency: out_valid SHALL rise at the WIDTH-th rising edge after the acceptance edge.
REQ-020 DONE: diff SHALL equal the assembled result register; borrow_out SHALL equal the final borrow flop.
REQ-021 DONE: overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched original operand MSBs.
REQ-022 DONE: zero SHALL equal (diff == 0).
REQ-023 DONE: diff, borrow_out, overflow and zero SHALL be held stable until out_valid && out_ready at an edge; the block SHALL then go to IDLE.
REQ-024 Accept-to-accept minimum SHALL be WIDTH+2 cycles; no same-cycle DONE->accept.
REQ-025 in_valid while not in IDLE SHALL be ignored; changes on a and b outside the acceptance edge SHALL have no effect.
REQ-026 out_ready while not in DONE SHALL be ignored.
REQ-027 Outside DONE, diff, borrow_out, overflow and zero SHALL read 0.
REQ-028 Bit counter width SHALL be clog2(WIDTH+1) bits; the counter SHALL not wrap during RUN.

Reset
REQ-029 rst_n low at an edge SHALL force state to IDLE and clear operand registers, result register, borrow flop, counter and latched MSBs, regardless of state (including mid-RUN or DONE); a held result is discarded.
REQ-030 After reset: in_ready = 1, out_valid = 0, diff = 0, borrow_out = 0, overflow = 0, zero = 0.
REQ-031 An in_valid asserted on a reset edge SHALL not be accepted.

Verification (WIDTH = 8)
REQ-032 Bench SHALL cover: a=0xC8, b=0x37 -> diff=0x91, borrow_out=0, overflow=0, zero=0; out_valid exactly 8 edges after acceptance.
REQ-033 Bench SHALL cover: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, overflow=0, zero=0.
REQ-034 Bench SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; and a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-035 Bench SHALL cover: a=0x5A, b=0x5A -> diff=0x00, zero=1, borrow_out=0, overflow=0.
REQ-036 Bench SHALL cover backpressure: out_ready low 5 cycles in DONE with in_valid high and new operands -> outputs stable, in_ready=0, new operands not taken; out_ready high -> IDLE next edge, then new operands accepted.
REQ-037 Bench SHALL cover reset during RUN after 3 bits -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a following 0x10-0x01 yields 0x0F.
REQ-038 Bench SHALL check exhaustive compare: all 65536 (a, b) pairs against a reference model.
